id_decode_stage: RTL
====================

ID_DECODE_STAGE -- requirements
Module: id_decode_stage

Interface
REQ-001 Parameters: XLEN, default 32, datapath width; NREG, default 32, register count (power of 2); AW = log2(NREG), derived, register index width; CNT_W, default 16, bubble counter width.
REQ-002 Ports: clk  in  1  rising-edge clock; rst_n  in  1  reset, synchronous, active-low.
REQ-003 Ports: Instruc_IFID  in  32  instruction; PC_IFID  in  XLEN  its PC; valid_IFID  in  1  IF/ID slot holds an instruction.
REQ-004 Ports: write_Data  in  XLEN  WB data; rd  in  AW  WB destination; RegWrite  in  1  WB write enable.
REQ-005 Ports: flush_i  in  1  branch taken in EX, kill ID; ex_hold_i  in  1  EX cannot accept, hold ID/EX.
REQ-006 Ports: stall_o  out  1  IF and IF/ID must hold; bubble_cnt_o  out  CNT_W  bubbles inserted since reset.
REQ-007 Ports (ID/EX register outputs): read_data1_IDEX, read_data2_IDEX, imm_IDEX  out  XLEN; PC_IDEX  out  XLEN; instruc_IDEX  out  32; rd_IDEX  out  AW; valid_IDEX  out  1; branch_IDEX, memRead_IDEX, mem2reg_IDEX, memWrite_IDEX, ALUSrc_IDEX, RegWrite_IDEX  out  1 each; ALUOp_IDEX  out  2.

Function
REQ-008 Decode by opcode [6:0] into {ALUSrc,mem2reg,regWrite,memRead,memWrite,branch,ALUOp}: 0110011 -> 0,0,1,0,0,0,10; 0010011 -> 1,0,1,0,0,0,10; 0000011 -> 1,1,1,1,0,0,00; 0100011 -> 1,0,0,0,1,0,00; 1100011 -> 0,0,0,0,0,1,01; any other -> all 0.
REQ-009 Immediate, sign-extended to XLEN: I-type (0010011, 0000011) instr[31:20]; S-type {instr[31:25],instr[11:7]}; B-type {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}; other 0.
REQ-010 rs1 = instr[15+AW-1:15], rs2 = instr[20+AW-1:20], destination = instr[7+AW-1:7].
REQ-011 Register 0 reads 0 always; writes to register 0 ignored.
REQ-012 Write-first bypass: RegWrite=1, rd!=0, rd==rs1 (rs2) -> read data 1 (2) equals write_Data in the same cycle; register array updated at the clock edge.
REQ-013 Load-use hazard (combinational) = valid_IDEX & memRead_IDEX & rd_IDEX!=0 & (rd_IDEX==rs1 | rd_IDEX==rs2) & valid_IFID.
REQ-014 stall_o = ~flush_i & (ex_hold_i | load-use hazard).
REQ-015 Per-edge priority, highest first: reset; flush_i -> bubble; ex_hold_i -> all ID/EX outputs keep value; load-use -> bubble; else load decoded instruction.
REQ-016 Bubble: valid_IDEX=0 and all seven control outputs 0; data fields (data, imm, PC, instr, rd) loaded from current decode.
REQ-017 Normal load: all ID/EX fields from decode; valid_IDEX=valid_IFID; control outputs forced 0 when valid_IFID=0.
REQ-018 Latency: one cycle from IF/ID to ID/EX; a load-use stall lasts exactly one cycle, then the held instruction issues.
REQ-019 bubble_cnt_o increments by 1 on each edge where REQ-016 bubble is written (flush or load-use, not hold); saturates at all-ones.
REQ-020 Register file writes occur regardless of stall, hold or flush.

Reset
REQ-021 On rising clk with rst_n=0: every ID/EX output 0, valid_IDEX 0, bubble_cnt_o 0, all registers 0.
REQ-022 Reset mid-stall discards the held instruction; stall_o follows REQ-014 from reset state (0 unless ex_hold_i).

Structure
REQ-023 Shared package holds opcode constants, ALUOp encodings, and the 8-bit control-bundle typedef with field order of REQ-008.
REQ-024 One sub-module, regfile_param (XLEN, NREG; two read, one write, bypass, x0 hardwired); decode, imm-gen, hazard logic and ID/EX register inline.

Verification
REQ-025 WB writes x5=0x1234 while ID reads rs1=x5 same cycle -> read_data1_IDEX=0x1234 next edge; write to x0 then read x0 -> 0.
REQ-026 lw x3 in ID/EX then add x4,x3,x1 in ID -> stall_o=1 one cycle, bubble (valid_IDEX=0, controls 0), bubble_cnt_o+1, add issues next cycle.
REQ-027 flush_i=1 with ex_hold_i=1 and load-use active -> bubble written, stall_o=0, bubble_cnt_o+1.
REQ-028 ex_hold_i=1 for 3 cycles -> ID/EX outputs unchanged, stall_o=1, bubble_cnt_o unchanged.
REQ-029 sw (0100011) with imm bits 0xFFF -> imm_IDEX=0xFFFFFFFF, memWrite_IDEX=1, ALUSrc_IDEX=1, RegWrite_IDEX=0; beq -> branch_IDEX=1, ALUOp=01.
REQ-030 CNT_W=4, 20 flushes -> bubble_cnt_o saturates at 15; rst_n=0 one edge -> all outputs 0.

Source files
------------

// File: rtl/id_decode_stage_pkg.sv
// Shared definitions for the instruction decode stage: opcodes, ALUOp codes
// and the packed control bundle carried into the ID/EX register.
package id_decode_stage_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    typedef struct packed {
        logic       alu_src;
        logic       mem2reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE:  c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_FUNC};
            OP_ITYPE:  c = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_FUNC};
            OP_LOAD:   c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD};
            OP_STORE:  c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_ADD};
            OP_BRANCH: c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_BR};
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_decode_stage_regfile.sv
// Two-read, one-write register file with x0 hardwired to zero and
// write-first bypass so a same-cycle WB value is visible to the reader.
module regfile_param
    import id_decode_stage_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_i,
    input  logic [AW-1:0]   rs2_i,
    input  logic [AW-1:0]   rd_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            we_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (rd_i != '0)) begin
            regs_q[rd_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = regs_q[rs1_i];
        rdata2_o = regs_q[rs2_i];
        // Entry 0 is never written but reset only clears it once; force zero anyway.
        if (rs1_i == '0) begin
            rdata1_o = '0;
        end else if (we_i && (rd_i == rs1_i)) begin
            rdata1_o = wdata_i;
        end
        if (rs2_i == '0) begin
            rdata2_o = '0;
        end else if (we_i && (rd_i == rs2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction decode stage: control decode, immediate generation, load-use
// hazard detection and the ID/EX pipeline register with a bubble counter.
module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int NREG  = 32,
    parameter  int CNT_W = 16,
    localparam int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      Instruc_IFID,
    input  logic [XLEN-1:0]  PC_IFID,
    input  logic             valid_IFID,
    input  logic [XLEN-1:0]  write_Data,
    input  logic [AW-1:0]    rd,
    input  logic             RegWrite,
    input  logic             flush_i,
    input  logic             ex_hold_i,
    output logic             stall_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [XLEN-1:0]  read_data1_IDEX,
    output logic [XLEN-1:0]  read_data2_IDEX,
    output logic [XLEN-1:0]  imm_IDEX,
    output logic [XLEN-1:0]  PC_IDEX,
    output logic [31:0]      instruc_IDEX,
    output logic [AW-1:0]    rd_IDEX,
    output logic             valid_IDEX,
    output logic             branch_IDEX,
    output logic             memRead_IDEX,
    output logic             mem2reg_IDEX,
    output logic             memWrite_IDEX,
    output logic             ALUSrc_IDEX,
    output logic             RegWrite_IDEX,
    output logic [1:0]       ALUOp_IDEX
);

    logic [6:0]      opcode;
    logic [AW-1:0]   rs1, rs2, rd_dec;
    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] imm_dec;
    logic [XLEN-1:0] rdata1, rdata2;
    logic            load_use;
    logic            bubble;

    ctrl_t           ctrl_q, ctrl_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d;
    logic [31:0]     ins_q, ins_d;
    logic [AW-1:0]   rdx_q, rdx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign opcode   = Instruc_IFID[6:0];
    assign rs1      = Instruc_IFID[15 +: AW];
    assign rs2      = Instruc_IFID[20 +: AW];
    assign rd_dec   = Instruc_IFID[7 +: AW];
    assign dec_ctrl = decode_ctrl(opcode);

    always_comb begin
        imm_dec = '0;
        case (opcode)
            OP_ITYPE, OP_LOAD: imm_dec = {{(XLEN-12){Instruc_IFID[31]}}, Instruc_IFID[31:20]};
            OP_STORE:          imm_dec = {{(XLEN-12){Instruc_IFID[31]}}, Instruc_IFID[31:25],
                                          Instruc_IFID[11:7]};
            OP_BRANCH:         imm_dec = {{(XLEN-12){Instruc_IFID[31]}}, Instruc_IFID[7],
                                          Instruc_IFID[30:25], Instruc_IFID[11:8], 1'b0};
            default:           imm_dec = '0;
        endcase
    end

    regfile_param #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .rd_i     (rd),
        .wdata_i  (write_Data),
        .we_i     (RegWrite),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    assign load_use = valid_q & ctrl_q.mem_read & (rdx_q != '0) &
                      ((rdx_q == rs1) | (rdx_q == rs2)) & valid_IFID;
    assign stall_o  = ~flush_i & (ex_hold_i | load_use);
    // Flush outranks hold; a load-use bubble only happens when EX is accepting.
    assign bubble   = flush_i | (~ex_hold_i & load_use);

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        rdx_d   = rdx_q;
        cnt_d   = cnt_q;
        if (bubble || !ex_hold_i) begin
            rd1_d = rdata1;
            rd2_d = rdata2;
            imm_d = imm_dec;
            pc_d  = PC_IFID;
            ins_d = Instruc_IFID;
            rdx_d = rd_dec;
            if (bubble) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                valid_d = valid_IFID;
                ctrl_d  = valid_IFID ? dec_ctrl : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            ins_q   <= '0;
            rdx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            rdx_q   <= rdx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bubble_cnt_o    = cnt_q;
    assign read_data1_IDEX = rd1_q;
    assign read_data2_IDEX = rd2_q;
    assign imm_IDEX        = imm_q;
    assign PC_IDEX         = pc_q;
    assign instruc_IDEX    = ins_q;
    assign rd_IDEX         = rdx_q;
    assign valid_IDEX      = valid_q;
    assign ALUSrc_IDEX     = ctrl_q.alu_src;
    assign mem2reg_IDEX    = ctrl_q.mem2reg;
    assign RegWrite_IDEX   = ctrl_q.reg_write;
    assign memRead_IDEX    = ctrl_q.mem_read;
    assign memWrite_IDEX   = ctrl_q.mem_write;
    assign branch_IDEX     = ctrl_q.branch;
    assign ALUOp_IDEX      = ctrl_q.alu_op;

endmodule
